// File: rtl/bank_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// bank_cmd_arbiter
//
// Shares the single DRAM command slot between NUM_BANKS per-bank schedulers.
// One bank is granted per cycle, round-robin among banks whose pending command
// matches the current bus direction (read or write). Same-direction commands
// are batched to limit bus turnaround; a batch is capped at MAX_STREAK grants
// while the opposite direction is waiting. Every read<->write switch costs one
// decision cycle plus TURN_GAP idle turnaround cycles.
//
// Ports
//   clk        in   1          clock
//   rst        in   1          synchronous reset, active-high
//   req_valid  in   NUM_BANKS  bank i has a command ready
//   req_type   in   NUM_BANKS  per-bank direction: 0=read, 1=write
//   cmd_ready  in   1          command encoder can accept a command
//   grant      out  NUM_BANKS  one-hot grant; bank i pops when grant[i]=1
//   cmd_valid  out  1          a command is issued this cycle (|grant)
//   cmd_bank   out  BANK_LOG   index of the granted bank (0 when idle)
//   cmd_type   out  1          direction of the issued command (0 when idle)
//   turn_busy  out  1          bus turnaround in progress; no grant possible
// ---------------------------------------------------------------------------
module bank_cmd_arbiter #(
  parameter int NUM_BANKS  = 16,
  parameter int BANK_LOG   = 4,
  parameter int MAX_STREAK = 8,
  parameter int TURN_GAP   = 2,
  parameter int STREAK_W   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_BANKS-1:0] req_valid,
  input  logic [NUM_BANKS-1:0] req_type,
  input  logic                 cmd_ready,
  output logic [NUM_BANKS-1:0] grant,
  output logic                 cmd_valid,
  output logic [BANK_LOG-1:0]  cmd_bank,
  output logic                 cmd_type,
  output logic                 turn_busy
);

  localparam int GAP_W = $clog2(TURN_GAP + 1);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_TURN = 1'b1;

  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_STREAK);
  localparam logic [GAP_W-1:0]    GAP_INIT   = GAP_W'(TURN_GAP);
  localparam logic [GAP_W-1:0]    GAP_LAST   = GAP_W'(1);

  // Registered state
  logic [0:0]          state;
  logic                cur_type;
  logic [BANK_LOG-1:0] rr_ptr;
  logic [STREAK_W-1:0] streak;
  logic [GAP_W-1:0]    gap_cnt;

  // Request sets split by direction relative to the current bus direction
  logic [NUM_BANKS-1:0] same_set;
  logic [NUM_BANKS-1:0] other_set;
  logic                 same_any;
  logic                 other_any;

  assign same_set  = req_valid & ~(req_type ^ {NUM_BANKS{cur_type}});
  assign other_set = req_valid &  (req_type ^ {NUM_BANKS{cur_type}});
  assign same_any  = |same_set;
  assign other_any = |other_set;

  // Round-robin pick: first bank in same_set at or after rr_ptr. The index
  // sum is BANK_LOG bits wide, so it wraps mod NUM_BANKS for free.
  logic                pick_found;
  logic [BANK_LOG-1:0] pick_idx;

  always_comb begin
    // NOTE: every combinational output gets a default before the loop so no
    // path leaves it unassigned, which would otherwise infer a latch.
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 0; k < NUM_BANKS; k++) begin
      if (!pick_found && same_set[rr_ptr + BANK_LOG'(k)]) begin
        pick_found = 1'b1;
        pick_idx   = rr_ptr + BANK_LOG'(k);
      end
    end
  end

  // Decision logic for the RUN state
  logic is_run;
  logic streak_ok;
  logic do_grant;
  logic do_switch;

  assign is_run    = !rst && (state == ST_RUN);
  // Batch may continue while under the cap, or indefinitely if nobody waits
  assign streak_ok = (streak < STREAK_MAX) || !other_any;
  assign do_grant  = is_run && cmd_ready && same_any && streak_ok;
  // Switch when the other direction waits and this cycle cannot grant.
  // With cmd_ready low, pending same-direction work pins the direction.
  assign do_switch = is_run && other_any && !(same_any && (!cmd_ready || streak_ok));

  // Outputs: combinational from registered state and current inputs
  assign grant     = do_grant ? (NUM_BANKS'(1) << pick_idx) : '0;
  assign cmd_valid = do_grant;
  assign cmd_bank  = do_grant ? pick_idx : '0;
  assign cmd_type  = do_grant & cur_type;
  assign turn_busy = !rst && (state == ST_TURN);

  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous and active-high to match the surrounding
    // controller; all state uses non-blocking assignment so every register
    // samples the same pre-edge values.
    if (rst) begin
      state    <= ST_RUN;
      cur_type <= 1'b0;
      rr_ptr   <= '0;
      streak   <= '0;
      gap_cnt  <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (do_grant) begin
            rr_ptr <= pick_idx + 1'b1;
            if (streak < STREAK_MAX) begin
              streak <= streak + 1'b1;
            end
          end else if (do_switch) begin
            state    <= ST_TURN;
            cur_type <= ~cur_type;
            streak   <= '0;
            gap_cnt  <= GAP_INIT;
          end
        end
        ST_TURN: begin
          // Fixed-length gap; requests seen during it are ignored
          gap_cnt <= gap_cnt - 1'b1;
          if (gap_cnt == GAP_LAST) begin
            state <= ST_RUN;
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_bank_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bank_cmd_arbiter
//
// Self-checking bench for bank_cmd_arbiter. A behavioural model tracks the
// arbiter's bus direction, round-robin pointer, batch length and remaining
// turnaround time, and predicts the full output bundle each cycle from the
// arbitration rules. Directed scenarios add hand-derived expectations.
// ---------------------------------------------------------------------------
module tb_bank_cmd_arbiter;

  localparam int NB   = 16;
  localparam int BL   = 4;
  localparam int MAXS = 8;
  localparam int GAP  = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [NB-1:0] req_valid = '0;
  logic [NB-1:0] req_type  = '0;
  logic          cmd_ready = 1'b0;
  logic [NB-1:0] grant;
  logic          cmd_valid;
  logic [BL-1:0] cmd_bank;
  logic          cmd_type;
  logic          turn_busy;

  int tests_run = 0;
  int fails     = 0;

  bank_cmd_arbiter #(
    .NUM_BANKS (NB),
    .BANK_LOG  (BL),
    .MAX_STREAK(MAXS),
    .TURN_GAP  (GAP),
    .STREAK_W  (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_type (req_type),
    .cmd_ready(cmd_ready),
    .grant    (grant),
    .cmd_valid(cmd_valid),
    .cmd_bank (cmd_bank),
    .cmd_type (cmd_type),
    .turn_busy(turn_busy)
  );

  always #5 clk = ~clk;

  // Full observed output bundle: {grant, cmd_valid, cmd_bank, cmd_type, turn_busy}
  logic [NB+BL+2:0] obs;
  assign obs = {grant, cmd_valid, cmd_bank, cmd_type, turn_busy};

  // ---------------- behavioural model ----------------
  bit               m_turn;      // in turnaround
  bit               m_dir;       // current direction, 0=read
  int               m_ptr;       // next bank to favour
  int               m_streak;    // grants in the current batch
  int               m_gap;       // turnaround cycles still to go
  int               m_pick;      // bank granted this cycle, -1 if none
  bit               m_same_any;
  bit               m_other_any;
  logic [NB+BL+2:0] exp_vec;

  task automatic model_eval();
    logic [NB-1:0] g;
    g           = '0;
    m_pick      = -1;
    exp_vec     = '0;
    m_same_any  = 1'b0;
    m_other_any = 1'b0;
    for (int i = 0; i < NB; i++) begin
      if (req_valid[i]) begin
        if (req_type[i] == m_dir) m_same_any = 1'b1;
        else                      m_other_any = 1'b1;
      end
    end
    if (rst) return;
    if (m_turn) begin
      exp_vec = 1;
      return;
    end
    if (cmd_ready && m_same_any && (m_streak < MAXS || !m_other_any)) begin
      for (int k = 0; k < NB; k++) begin
        int b;
        b = (m_ptr + k) % NB;
        if (m_pick < 0 && req_valid[b] && req_type[b] == m_dir) m_pick = b;
      end
    end
    if (m_pick >= 0) begin
      g[m_pick] = 1'b1;
      exp_vec   = {g, 1'b1, BL'(m_pick), m_dir, 1'b0};
    end
  endtask

  task automatic model_advance();
    if (rst) begin
      m_turn = 0; m_dir = 0; m_ptr = 0; m_streak = 0; m_gap = 0;
    end else if (m_turn) begin
      m_gap--;
      if (m_gap == 0) m_turn = 0;
    end else if (m_pick >= 0) begin
      m_ptr = (m_pick + 1) % NB;
      if (m_streak < MAXS) m_streak++;
    end else if (m_other_any && (cmd_ready || !m_same_any)) begin
      m_turn   = 1;
      m_dir    = !m_dir;
      m_streak = 0;
      m_gap    = GAP;
    end
  endtask

  // One reset cycle followed by one idle cycle; nothing compared here.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = '0; req_type = '0; cmd_ready = 1'b1;
    #1 model_eval();
    model_advance();
    @(negedge clk);
    rst = 1'b0;
    #1 model_eval();
    model_advance();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rst = 1'b1; req_valid = NB'($urandom) | 16'h0001;
      req_type = NB'($urandom); cmd_ready = 1'b1;
      #1 model_eval();
      tests_run++;
      if (obs !== '0 || obs !== exp_vec) begin
        fails++;
        $display("FAIL reset_outputs cyc %0d: got %h want 0", i, obs);
      end
      model_advance();
    end
    rst = 1'b0;
  endtask

  task automatic test_alternate();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      req_valid = 16'h0081; req_type = '0; cmd_ready = 1'b1;
      #1 model_eval();
      tests_run++;
      if (obs !== exp_vec) begin
        fails++;
        $display("FAIL alternate_model cyc %0d: got %h want %h", i, obs, exp_vec);
      end
      tests_run++;
      if (cmd_valid !== 1'b1 || cmd_bank !== BL'((i % 2) ? 7 : 0) || turn_busy !== 1'b0) begin
        fails++;
        $display("FAIL alternate_bank cyc %0d: got v=%b b=%0d busy=%b want v=1 b=%0d busy=0",
                 i, cmd_valid, cmd_bank, turn_busy, (i % 2) ? 7 : 0);
      end
      model_advance();
    end
  endtask

  task automatic test_all_reads();
    do_reset();
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      req_valid = '1; req_type = '0; cmd_ready = 1'b1;
      #1 model_eval();
      tests_run++;
      if (obs !== exp_vec) begin
        fails++;
        $display("FAIL all_reads_model cyc %0d: got %h want %h", i, obs, exp_vec);
      end
      tests_run++;
      if (cmd_valid !== 1'b1 || cmd_bank !== BL'(i % NB) || cmd_type !== 1'b0) begin
        fails++;
        $display("FAIL all_reads_bank cyc %0d: got v=%b b=%0d t=%b want v=1 b=%0d t=0",
                 i, cmd_valid, cmd_bank, cmd_type, i % NB);
      end
      model_advance();
    end
  endtask

  task automatic test_streak_switch();
    logic [6:0] want;   // {valid, bank, type, busy}
    do_reset();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      req_valid = 16'h0028; req_type = 16'h0020; cmd_ready = 1'b1;
      #1 model_eval();
      if (i < MAXS)             want = {1'b1, 4'd3, 1'b0, 1'b0};
      else if (i == MAXS)       want = 7'b0;
      else if (i <= MAXS + GAP) want = 7'b1;
      else                      want = {1'b1, 4'd5, 1'b1, 1'b0};
      tests_run++;
      if (obs !== exp_vec) begin
        fails++;
        $display("FAIL streak_model cyc %0d: got %h want %h", i, obs, exp_vec);
      end
      tests_run++;
      if ({cmd_valid, cmd_bank, cmd_type, turn_busy} !== want) begin
        fails++;
        $display("FAIL streak_seq cyc %0d: got %b want %b", i,
                 {cmd_valid, cmd_bank, cmd_type, turn_busy}, want);
      end
      model_advance();
    end
  endtask

  task automatic test_writes_only();
    logic [NB-1:0] wset;
    int            wr_grants;
    wset = NB'($urandom) & 16'hFFFE;
    if (wset == '0) wset = 16'h0002;
    wr_grants = 0;
    do_reset();
    // Phase A: build a read batch of 5; Phase B: writes only; Phase C: writes
    // plus a waiting read, so the write batch length shows the restarted streak.
    for (int i = 0; i < 5 + 3 + MAXS + 1; i++) begin
      @(negedge clk);
      cmd_ready = 1'b1;
      if (i < 5)          begin req_valid = 16'h0001;        req_type = '0;   end
      else if (i < 8)     begin req_valid = wset;            req_type = wset; end
      else                begin req_valid = wset | 16'h0001; req_type = wset; end
      #1 model_eval();
      tests_run++;
      if (obs !== exp_vec) begin
        fails++;
        $display("FAIL writes_model cyc %0d: got %h want %h", i, obs, exp_vec);
      end
      if (i == 5 || i == 6 || i == 7) begin
        tests_run++;
        if (cmd_valid !== 1'b0 || turn_busy !== (i != 5)) begin
          fails++;
          $display("FAIL writes_switch cyc %0d: got v=%b busy=%b want v=0 busy=%b",
                   i, cmd_valid, turn_busy, i != 5);
        end
      end
      if (i >= 8 && cmd_valid === 1'b1 && cmd_type === 1'b1) wr_grants++;
      model_advance();
    end
    tests_run++;
    if (wr_grants != MAXS) begin
      fails++;
      $display("FAIL writes_batch_len: got %0d write grants want %0d", wr_grants, MAXS);
    end
  endtask

  task automatic test_not_ready();
    logic [6:0] want;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      req_valid = 16'h0204; req_type = '0;
      cmd_ready = (i == 0 || i >= 6);
      #1 model_eval();
      if (i == 0 || i == 7) want = {1'b1, 4'd2, 1'b0, 1'b0};
      else if (i == 6)      want = {1'b1, 4'd9, 1'b0, 1'b0};
      else                  want = 7'b0;
      tests_run++;
      if (obs !== exp_vec) begin
        fails++;
        $display("FAIL not_ready_model cyc %0d: got %h want %h", i, obs, exp_vec);
      end
      tests_run++;
      if ({cmd_valid, cmd_bank, cmd_type, turn_busy} !== want) begin
        fails++;
        $display("FAIL not_ready_seq cyc %0d: got %b want %b", i,
                 {cmd_valid, cmd_bank, cmd_type, turn_busy}, want);
      end
      model_advance();
    end
  endtask

  task automatic test_reset_in_turn();
    logic [6:0] want;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      cmd_ready = 1'b1;
      rst       = (i == 1);
      if (i == 0) begin req_valid = 16'h0002; req_type = 16'h0002; end
      else        begin req_valid = 16'h0812; req_type = 16'h0002; end
      #1 model_eval();
      case (i)
        0:       want = 7'b0;                        // switch decision
        1:       want = 7'b0;                        // reset forces outputs low
        2:       want = {1'b1, 4'd4, 1'b0, 1'b0};    // RUN/read, ptr 0
        default: want = {1'b1, 4'd11, 1'b0, 1'b0};
      endcase
      tests_run++;
      if (obs !== exp_vec) begin
        fails++;
        $display("FAIL rst_turn_model cyc %0d: got %h want %h", i, obs, exp_vec);
      end
      tests_run++;
      if ({cmd_valid, cmd_bank, cmd_type, turn_busy} !== want) begin
        fails++;
        $display("FAIL rst_turn_seq cyc %0d: got %b want %b", i,
                 {cmd_valid, cmd_bank, cmd_type, turn_busy}, want);
      end
      model_advance();
    end
    rst = 1'b0;
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 1) == 0) begin
        req_valid = NB'($urandom) & NB'($urandom);
        req_type  = NB'($urandom);
      end
      cmd_ready = ($urandom_range(0, 9) < 8);
      #1 model_eval();
      tests_run++;
      if (obs !== exp_vec) begin
        fails++;
        bad++;
        if (bad <= 10)
          $display("FAIL random_model cyc %0d: got %h want %h (rv=%h rt=%h rdy=%b rst=%b)",
                   i, obs, exp_vec, req_valid, req_type, cmd_ready, rst);
      end
      model_advance();
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_alternate();
    test_all_reads();
    test_streak_switch();
    test_writes_only();
    test_not_ready();
    test_reset_in_turn();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
